// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out serializer with ready/valid load, a one-word holding
// buffer for gapless streaming, per-word bit order and frame start/end markers.
module piso_serializer_hs #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  lsb_first,
  output logic                  srl_out,
  output logic                  srl_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy
);

  localparam int unsigned    CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  typedef struct packed {
    logic                  lsb_first;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  state_t           state_q, state_d;
  word_t            hold_q, hold_d;
  word_t            sreg_q, sreg_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             srl_out_d, srl_valid_d, frame_start_d, frame_end_d, busy_d;
  logic             accept;

  // No bypass: a word is taken only while the holding buffer is empty.
  assign accept = load_valid && !hold_full_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    sreg_d        = sreg_q;
    bit_cnt_d     = bit_cnt_q;
    srl_out_d     = srl_out;
    srl_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;

    if (accept) begin
      hold_d      = '{lsb_first: lsb_first, data: data_in};
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        srl_out_d = IDLE_LEVEL;
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift) begin
          srl_out_d     = sreg_q.lsb_first ? sreg_q.data[0] : sreg_q.data[DATA_WIDTH-1];
          srl_valid_d   = 1'b1;
          frame_start_d = (bit_cnt_q == '0);
          frame_end_d   = (bit_cnt_q == LAST_BIT);
          sreg_d.data   = sreg_q.lsb_first ? (sreg_q.data >> 1) : (sreg_q.data << 1);
          if (bit_cnt_q == LAST_BIT) begin
            // Held word follows immediately so the line sees no idle tick.
            bit_cnt_d = '0;
            if (hold_full_q) begin
              sreg_d      = hold_q;
              hold_full_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT) || hold_full_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      srl_out     <= IDLE_LEVEL;
      srl_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      srl_out     <= srl_out_d;
      srl_valid   <= srl_valid_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
      busy        <= busy_d;
      load_ready  <= !hold_full_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Bench for piso_serializer_hs: 8-bit and 12-bit instances, serial stream
// compared against a word-to-bit-list reference model.
module tb_piso_serializer_hs;

  logic        tb_clk = 1'b0;
  logic        rst_n;
  logic        shift;
  logic        load_valid, load_ready, lsb_first;
  logic [7:0]  data_in;
  logic        srl_out, srl_valid, frame_start, frame_end, busy;
  logic        load_valid12, load_ready12, lsb12;
  logic [11:0] data12;
  logic        srl_out12, srl_valid12, frame_start12, frame_end12, busy12;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct { logic b; logic fs; logic fe; int cyc; } obs_t;
  typedef struct { logic b; logic fs; logic fe; } exp_t;
  obs_t obs[$];
  obs_t obs12[$];
  exp_t exp_q[$];
  exp_t exp12_q[$];

  always #5 tb_clk = ~tb_clk;

  piso_serializer_hs #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .clk(tb_clk), .rst_n(rst_n), .shift(shift),
    .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .lsb_first(lsb_first),
    .srl_out(srl_out), .srl_valid(srl_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );

  piso_serializer_hs #(.DATA_WIDTH(12), .IDLE_LEVEL(1'b1)) dut12 (
    .clk(tb_clk), .rst_n(rst_n), .shift(shift),
    .load_valid(load_valid12), .load_ready(load_ready12),
    .data_in(data12), .lsb_first(lsb12),
    .srl_out(srl_out12), .srl_valid(srl_valid12),
    .frame_start(frame_start12), .frame_end(frame_end12), .busy(busy12)
  );

  // Record every emitted bit with its cycle stamp.
  always @(posedge tb_clk) begin
    cyc = cyc + 1;
    #1;
    if (srl_valid === 1'b1)
      obs.push_back('{b: srl_out, fs: frame_start, fe: frame_end, cyc: cyc});
    if (srl_valid12 === 1'b1)
      obs12.push_back('{b: srl_out12, fs: frame_start12, fe: frame_end12, cyc: cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  // Reference: a word becomes DATA_WIDTH bits in the chosen order, first/last flagged.
  function automatic void model_word(input logic [7:0] d, input logic lsb);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{b: (lsb ? d[i] : d[7-i]), fs: (i == 0), fe: (i == 7)});
  endfunction

  function automatic void model_word12(input logic [11:0] d, input logic lsb);
    for (int i = 0; i < 12; i++)
      exp12_q.push_back('{b: (lsb ? d[i] : d[11-i]), fs: (i == 0), fe: (i == 11)});
  endfunction

  task automatic push8(input logic [7:0] d, input logic lsb);
    int n = 0;
    @(negedge tb_clk);
    data_in = d; lsb_first = lsb; load_valid = 1'b1;
    while (!load_ready && n < 100) begin @(negedge tb_clk); n++; end
    checks++;
    if (!load_ready) begin
      fails++;
      $display("FAIL push8_timeout: load_ready got %b required 1 within 100 cycles", load_ready);
      #1;
    end else begin
      @(posedge tb_clk);
      model_word(d, lsb);
      #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic push12(input logic [11:0] d, input logic lsb);
    int n = 0;
    @(negedge tb_clk);
    data12 = d; lsb12 = lsb; load_valid12 = 1'b1;
    while (!load_ready12 && n < 100) begin @(negedge tb_clk); n++; end
    checks++;
    if (!load_ready12) begin
      fails++;
      $display("FAIL push12_timeout: load_ready got %b required 1 within 100 cycles", load_ready12);
      #1;
    end else begin
      @(posedge tb_clk);
      model_word12(d, lsb);
      #1;
    end
    load_valid12 = 1'b0;
  endtask

  task automatic wait_idle(input bit wide);
    int n = 0;
    @(negedge tb_clk);
    while ((wide ? busy12 : busy) !== 1'b0 && n < 400) begin @(negedge tb_clk); n++; end
    checks++;
    if ((wide ? busy12 : busy) !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: busy got %b required 0 within 400 cycles", wide ? busy12 : busy);
    end
    @(negedge tb_clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; shift = 1'b0; load_valid = 1'b0; data_in = '0; lsb_first = 1'b0;
    load_valid12 = 1'b0; data12 = '0; lsb12 = 1'b0;
    repeat (3) @(negedge tb_clk);
    checks++;
    if ({srl_out, srl_valid, frame_start, frame_end, busy, load_ready} !== 6'b100001) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 100001",
               {srl_out, srl_valid, frame_start, frame_end, busy, load_ready});
    end
    checks++;
    if ({srl_out12, srl_valid12, busy12, load_ready12} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_outputs12: got %b required 1001",
               {srl_out12, srl_valid12, busy12, load_ready12});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle;
    shift = 1'b1;
    obs.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_clk);
      checks++;
      if ({srl_out, srl_valid, busy, load_ready} !== 4'b1001) begin
        fails++;
        $display("FAIL idle_cycle%0d: {out,valid,busy,ready} got %b required 1001", i,
                 {srl_out, srl_valid, busy, load_ready});
      end
    end
    checks++;
    if (obs.size() !== 0) begin
      fails++;
      $display("FAIL idle_pulses: got %0d required 0", obs.size());
    end
  endtask

  task automatic test_bit_order;
    shift = 1'b1;
    obs.delete(); exp_q.delete(); obs12.delete(); exp12_q.delete();
    push8(8'h1E, 1'b0);
    wait_idle(1'b0);
    push8(8'h1E, 1'b1);
    wait_idle(1'b0);
    push12(12'hA5C, 1'b0);
    wait_idle(1'b1);
    checks++;
    if (obs.size() !== 16) begin
      fails++;
      $display("FAIL order_count: got %0d pulses required 16", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].fs !== exp_q[i].fs || obs[i].fe !== exp_q[i].fe) begin
        fails++;
        $display("FAIL order_bit%0d: {b,fs,fe} got %b%b%b required %b%b%b", i,
                 obs[i].b, obs[i].fs, obs[i].fe, exp_q[i].b, exp_q[i].fs, exp_q[i].fe);
      end
    end
    checks++;
    if (obs12.size() !== 12) begin
      fails++;
      $display("FAIL w12_count: got %0d pulses required 12", obs12.size());
    end
    for (int i = 0; i < obs12.size() && i < exp12_q.size(); i++) begin
      checks++;
      if (obs12[i].b !== exp12_q[i].b || obs12[i].fs !== exp12_q[i].fs ||
          obs12[i].fe !== exp12_q[i].fe) begin
        fails++;
        $display("FAIL w12_bit%0d: {b,fs,fe} got %b%b%b required %b%b%b", i,
                 obs12[i].b, obs12[i].fs, obs12[i].fe, exp12_q[i].b, exp12_q[i].fs, exp12_q[i].fe);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] third;
    logic       third_lsb;
    third = 8'($urandom);
    third_lsb = 1'($urandom);
    shift = 1'b1;
    obs.delete(); exp_q.delete();
    push8(8'h1E, 1'b0);
    push8(8'hC3, 1'b0);
    push8(third, third_lsb);
    #1;
    // Third word is taken the edge after 0xC3 reloads, i.e. alongside C3's first bit.
    checks++;
    if (obs.size() !== 9) begin
      fails++;
      $display("FAIL b2b_third_accept: pulses before accept got %0d required 9", obs.size());
    end
    wait_idle(1'b0);
    checks++;
    if (obs.size() !== 24) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses required 24", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].fs !== exp_q[i].fs || obs[i].fe !== exp_q[i].fe ||
          (i > 0 && obs[i].cyc !== obs[i-1].cyc + 1)) begin
        fails++;
        $display("FAIL b2b_bit%0d: {b,fs,fe} got %b%b%b required %b%b%b, gap %0d required 1", i,
                 obs[i].b, obs[i].fs, obs[i].fe, exp_q[i].b, exp_q[i].fs, exp_q[i].fe,
                 (i > 0) ? obs[i].cyc - obs[i-1].cyc : 1);
      end
    end
  endtask

  task automatic test_paced;
    obs.delete(); exp_q.delete();
    shift = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge tb_clk);
      shift = (c % 4 == 3);
      if (c == 0) begin
        data_in = 8'hF0; lsb_first = 1'b0; load_valid = 1'b1;
        model_word(8'hF0, 1'b0);
      end else begin
        load_valid = 1'b0;
      end
      if (c >= 2 && obs.size() < 8) begin
        checks++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL paced_busy_c%0d: got %b required 1", c, busy);
        end
      end
      if (obs.size() >= 1 && obs.size() < 8) begin
        checks++;
        if (srl_out !== obs[obs.size()-1].b) begin
          fails++;
          $display("FAIL paced_hold_c%0d: srl_out got %b required %b", c, srl_out,
                   obs[obs.size()-1].b);
        end
      end
    end
    shift = 1'b1;
    checks++;
    if (obs.size() !== 8 || busy !== 1'b0) begin
      fails++;
      $display("FAIL paced_count: pulses got %0d busy %b required 8 busy 0", obs.size(), busy);
    end else begin
      checks++;
      if (obs[7].cyc - obs[0].cyc !== 28) begin
        fails++;
        $display("FAIL paced_span: got %0d cycles required 28", obs[7].cyc - obs[0].cyc);
      end
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].fs !== exp_q[i].fs || obs[i].fe !== exp_q[i].fe ||
          (i > 0 && obs[i].cyc - obs[i-1].cyc !== 4)) begin
        fails++;
        $display("FAIL paced_bit%0d: {b,fs,fe} got %b%b%b required %b%b%b", i,
                 obs[i].b, obs[i].fs, obs[i].fe, exp_q[i].b, exp_q[i].fs, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_random;
    bit pend = 1'b0;
    obs.delete(); exp_q.delete();
    load_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge tb_clk);
      if (pend) begin load_valid = 1'b0; pend = 1'b0; end
      shift = ($urandom_range(0, 2) != 0);
      if (!load_valid && $urandom_range(0, 2) == 0) begin
        data_in = 8'($urandom); lsb_first = 1'($urandom); load_valid = 1'b1;
      end
      if (load_valid && load_ready) begin
        model_word(data_in, lsb_first);
        pend = 1'b1;
      end
    end
    @(negedge tb_clk);
    load_valid = 1'b0;
    shift = 1'b1;
    wait_idle(1'b0);
    checks++;
    if (obs.size() !== exp_q.size() || obs.size() < 24) begin
      fails++;
      $display("FAIL rand_count: got %0d pulses required %0d (>=24)", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].fs !== exp_q[i].fs || obs[i].fe !== exp_q[i].fe) begin
        fails++;
        $display("FAIL rand_bit%0d: {b,fs,fe} got %b%b%b required %b%b%b", i,
                 obs[i].b, obs[i].fs, obs[i].fe, exp_q[i].b, exp_q[i].fs, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n = 0;
    int n0;
    shift = 1'b1;
    obs.delete(); exp_q.delete();
    push8(8'h1E, 1'b0);
    push8(8'h55, 1'b1);
    while (obs.size() < 3 && n < 100) begin @(posedge tb_clk); #2; n++; end
    checks++;
    if (obs.size() !== 3 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrst_setup: pulses got %0d ready %b required 3 ready 0",
               obs.size(), load_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({srl_out, srl_valid, frame_start, frame_end, busy, load_ready} !== 6'b100001) begin
      fails++;
      $display("FAIL midrst_async: got %b required 100001",
               {srl_out, srl_valid, frame_start, frame_end, busy, load_ready});
    end
    repeat (2) @(negedge tb_clk);
    rst_n = 1'b1;
    n0 = obs.size();
    repeat (30) @(negedge tb_clk);
    checks++;
    if (obs.size() !== n0 || load_ready !== 1'b1 || busy !== 1'b0 || srl_out !== 1'b1) begin
      fails++;
      $display("FAIL midrst_residual: extra pulses %0d ready %b busy %b out %b required 0 1 0 1",
               obs.size() - n0, load_ready, busy, srl_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_bit_order();
    test_back_to_back();
    test_paced();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer_hs.md
Name: piso_serializer_hs

Overview:
Parametrised parallel-in/serial-out serializer with a ready/valid load handshake and a one-entry holding buffer, so back-to-back words stream without gaps. The bit order is selectable per word. Frame start/end markers accompany the serial stream. It sits between the parallel datapath and the transceiver line driver and is paced by an external shift strobe (baud tick).

Parameters:
DATA_WIDTH, 8, word width in bits; must be >= 2.
IDLE_LEVEL, 1'b1, value driven on srl_out when no frame is active.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
shift  input  1  shift strobe; one serial bit is emitted per clk cycle with shift=1.
load_valid  input  1  data_in / lsb_first are valid.
load_ready  output  1  holding buffer empty; a word is accepted when load_valid=1 and load_ready=1 at a rising edge.
data_in  input  DATA_WIDTH  parallel word.
lsb_first  input  1  bit order for this word (1 = bit 0 first); latched with the word.
srl_out  output  1  serial data, registered.
srl_valid  output  1  1 for one cycle per emitted bit.
frame_start  output  1  qualifies the first bit of a word; coincident with srl_valid.
frame_end  output  1  qualifies the last bit of a word; coincident with srl_valid.
busy  output  1  1 while in SHIFT state or while the holding buffer is full.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; hold empty; bit_cnt=0; srl_out=IDLE_LEVEL; srl_valid, frame_start, frame_end and busy all 0; load_ready=1.
- Storage: hold_data/hold_lsb plus a hold_full flag; shift register sreg/sreg_lsb; bit counter bit_cnt of width clog2(DATA_WIDTH).
- load_ready = ~hold_full. There is no bypass: a full hold being drained in the same cycle still shows ready=0 that cycle.
- IDLE:
  - If hold_full: on the next edge, move hold into sreg, clear hold_full, set bit_cnt=0, go to SHIFT.
  - A shift tick in IDLE drives srl_out=IDLE_LEVEL with srl_valid=0.
- SHIFT, on a cycle with shift=1:
  - srl_out <= sreg[DATA_WIDTH-1] if MSB-first, sreg[0] if LSB-first.
  - srl_valid <= 1; frame_start <= (bit_cnt==0); frame_end <= (bit_cnt==DATA_WIDTH-1).
  - sreg shifts toward the emitting end; bit_cnt increments.
- SHIFT, on a cycle with shift=0: sreg, bit_cnt and srl_out hold; srl_valid, frame_start and frame_end are 0.
- Last bit (shift=1 and bit_cnt==DATA_WIDTH-1):
  - If hold_full: reload sreg from hold on the same edge, bit_cnt=0, stay in SHIFT. The next tick emits the new word's first bit with no idle tick.
  - Otherwise go to IDLE.
- Latency: a word accepted at edge N is in sreg at edge N+1. Its first bit appears on srl_out at the first shift=1 edge at or after N+2. Exception: when it reloads at a frame end, no idle cycle is inserted.
- Simultaneous accept and reload cannot occur, since accept requires hold empty. An accept and a last-bit tick in the same cycle are legal: the word lands in hold and, if hold was empty at the time, the serializer goes to IDLE and then reloads one cycle later.
- Reset mid-frame: the current and held words are discarded, no further srl_valid is produced, and outputs take their reset values immediately.
- bit_cnt never exceeds DATA_WIDTH-1 (no wrap past the frame).

Test Plan:
- Reset then idle, with shift tied 1 for 20 cycles and no load → srl_out=1, srl_valid=0, busy=0, load_ready=1 throughout.
- Load 0x1E with lsb_first=0 and shift=1 continuously → serial 0,0,0,1,1,1,1,0; frame_start on bit 1, frame_end on bit 8; exactly 8 srl_valid pulses.
- Load 0x1E with lsb_first=1 → serial 0,1,1,1,1,0,0,0. Then set DATA_WIDTH=12, load 0xA5C MSB-first → 1010_0101_1100.
- Back-to-back: load 0x1E then 0xC3 (MSB-first) with continuous shift:
  - 16 contiguous srl_valid pulses; frame_end on pulse 8, frame_start on pulse 9.
  - Third load held off (load_ready=0) until 0xC3 moves into sreg.
- Paced shift: shift=1 every 4th cycle with 0xF0 → one bit per tick, srl_out stable between ticks, 32 cycles for the frame, busy=1 for its whole duration.
- Assert rst_n=0 asynchronously after bit 3 of 0x1E with hold also full → srl_out=1 and srl_valid=0 immediately. After release, no residual bits are emitted and load_ready=1.
